// File: rtl/logs_pkg.sv
// Shared definitions for the logistic-map sonifier output path.
package logs_pkg;

  localparam int LEVEL_BITS_DEF = 8;
  localparam int STEP_CLKS_DEF  = 25_200;

  typedef enum logic [1:0] {
    MUTED    = 2'd0,
    FADE_IN  = 2'd1,
    PLAYING  = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

endpackage

// File: rtl/logs_divider.sv
// Free-running 0..N-1 counter; tick is high during the terminal count cycle.
module logs_divider #(
  parameter int N = logs_pkg::STEP_CLKS_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TC = CW'(N - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (count == TC)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  assign tick = (count == TC);

endmodule

// File: rtl/logs_fader.sv
// Click-free mute/fade stage: ramps a gain level and gates the PWM stream
// with a first-order delta-sigma density derived from that level.
//
// state    | meaning
// MUTED    | level 0, output silent
// FADE_IN  | level rises one LSB per tick
// PLAYING  | level at full scale, exact pass-through
// FADE_OUT | level falls one LSB per tick
module logs_fader #(
  parameter int LEVEL_BITS = logs_pkg::LEVEL_BITS_DEF,
  parameter int STEP_CLKS  = logs_pkg::STEP_CLKS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  snd_in,
  output logic                  snd,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  busy,
  output logic                  muted
);

  import logs_pkg::*;

  localparam logic [LEVEL_BITS-1:0] LMAX = '1;

  fade_state_t           state, state_nxt;
  logic [LEVEL_BITS-1:0] level_nxt;
  logic [LEVEL_BITS-1:0] acc;
  logic [LEVEL_BITS:0]   acc_sum;
  logic                  gate;
  logic                  tick;

  logs_divider #(.N(STEP_CLKS)) u_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // A direction change always takes priority over a pending level step.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    unique case (state)
      MUTED: begin
        level_nxt = '0;
        if (enable) state_nxt = FADE_IN;
      end
      FADE_IN: begin
        if (!enable) begin
          state_nxt = FADE_OUT;
        end else if (tick) begin
          if (level >= LMAX - 1'b1) begin
            level_nxt = LMAX;
            state_nxt = PLAYING;
          end else begin
            level_nxt = level + 1'b1;
          end
        end
      end
      PLAYING: begin
        level_nxt = LMAX;
        if (!enable) state_nxt = FADE_OUT;
      end
      FADE_OUT: begin
        if (enable) begin
          state_nxt = FADE_IN;
        end else if (tick) begin
          if (level <= 1) begin
            level_nxt = '0;
            state_nxt = MUTED;
          end else begin
            level_nxt = level - 1'b1;
          end
        end
      end
      default: begin
        state_nxt = MUTED;
        level_nxt = '0;
      end
    endcase
  end

  // Carry out of acc + level fires exactly level times per 2^LEVEL_BITS clocks.
  assign acc_sum = {1'b0, acc} + {1'b0, level};
  assign gate    = acc_sum[LEVEL_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MUTED;
      level <= '0;
      busy  <= 1'b0;
      muted <= 1'b1;
      acc   <= '0;
      snd   <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      busy  <= (state_nxt == FADE_IN) || (state_nxt == FADE_OUT);
      muted <= (state_nxt == MUTED);
      acc   <= acc_sum[LEVEL_BITS-1:0];
      snd   <= (level == LMAX) ? snd_in : (snd_in & gate);
    end
  end

endmodule

// File: tb/tb_logs_fader.sv
// Directed bench for logs_fader at LEVEL_BITS=4, STEP_CLKS=16.
module tb_logs_fader;
  import logs_pkg::*;

  localparam int LB   = 4;
  localparam int SC   = 16;
  localparam int LMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          snd_in;
  logic          snd;
  logic [LB-1:0] level;
  logic          busy;
  logic          muted;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logs_fader #(.LEVEL_BITS(LB), .STEP_CLKS(SC)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .snd_in (snd_in),
    .snd    (snd),
    .level  (level),
    .busy   (busy),
    .muted  (muted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_level(input int target, input int budget);
    int n;
    n = 0;
    while (int'(level) != target && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("wait_level_%0d", target), int'(level), target);
  endtask

  initial begin
    int ones, prev, last_chg, bad;
    reset  = 1'b1;
    enable = 1'b0;
    snd_in = 1'b0;

    // Reset state and long mute with snd_in high
    do_reset();
    chk("rst_level", int'(level), 0);
    chk("rst_muted", int'(muted), 1);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_snd",   int'(snd),   0);
    chk("rst_acc",   int'(dut.acc), 0);
    snd_in = 1'b1;
    ones = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      ones += int'(snd);
      if (!muted || level != 0) bad++;
    end
    chk("mute_snd_ones", ones, 0);
    chk("mute_state_bad", bad, 0);

    // Full fade-in: one step per 16 clocks, L ones per plateau
    do_reset();
    enable = 1'b1;
    snd_in = 1'b1;
    step();
    chk("en_busy",  int'(busy),  1);
    chk("en_muted", int'(muted), 0);
    chk("en_level", int'(level), 0);
    prev = 0; ones = int'(snd); last_chg = 0;
    while (!(int'(level) == LMAX) && cyc < 15 * 16 + 16) begin
      step();
      ones += int'(snd);
      if (int'(level) != prev) begin
        chk($sformatf("fin_step_%0d", prev), int'(level), prev + 1);
        chk($sformatf("fin_ones_%0d", prev), ones, prev);
        chk($sformatf("fin_gap_%0d", prev), cyc - last_chg, SC);
        last_chg = cyc;
        prev = int'(level);
        ones = 0;
      end
    end
    chk("play_level", int'(level), LMAX);
    chk("play_busy",  int'(busy),  0);
    chk("play_muted", int'(muted), 0);
    chk("play_cycle", cyc, 15 * 16);

    // Pass-through of a period-10 square wave
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      snd_in = ((i % 10) < 5) ? 1'b1 : 1'b0;
      step();
      if (snd != snd_in) bad++;
    end
    chk("pass_square_bad", bad, 0);
    snd_in = 1'b1; step(); chk("pass_hi", int'(snd), 1);
    snd_in = 1'b0; step(); chk("pass_lo", int'(snd), 0);

    // Reverse at level 7, then fade out to MUTED with snd_in low
    do_reset();
    enable = 1'b1;
    snd_in = 1'b0;
    wait_level(7, 200);
    enable = 1'b0;
    step();
    chk("rev_level", int'(level), 7);
    chk("rev_state", int'(dut.state), int'(FADE_OUT));
    chk("rev_busy",  int'(busy), 1);
    prev = 7; ones = 0; bad = 0;
    for (int i = 0; i < 200 && !muted; i++) begin
      step();
      ones += int'(snd);
      if (int'(level) != prev) begin
        if (int'(level) != prev - 1) bad++;
        prev = int'(level);
      end
    end
    chk("fout_muted", int'(muted), 1);
    chk("fout_level", int'(level), 0);
    chk("fout_step_bad", bad, 0);
    chk("fout_snd_ones", ones, 0);

    // Enable toggled every cycle freezes the level
    do_reset();
    enable = 1'b1;
    snd_in = 1'b1;
    wait_level(3, 100);
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      enable = ~enable;
      step();
      if (int'(level) != 3 || !busy) bad++;
    end
    chk("toggle_bad", bad, 0);
    chk("toggle_level", int'(level), 3);

    // Reset mid fade-out at level 9
    do_reset();
    enable = 1'b1;
    snd_in = 1'b1;
    wait_level(10, 300);
    enable = 1'b0;
    wait_level(9, 100);
    chk("pre_rst_state", int'(dut.state), int'(FADE_OUT));
    reset = 1'b1;
    step();
    chk("mrst_level", int'(level), 0);
    chk("mrst_snd",   int'(snd),   0);
    chk("mrst_muted", int'(muted), 1);
    chk("mrst_busy",  int'(busy),  0);
    chk("mrst_acc",   int'(dut.acc), 0);
    reset = 1'b0;
    step();
    chk("post_rst_snd", int'(snd), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logs_fader.md
# logs_fader

Click-free mute/fade output stage placed directly downstream of the logistic-map sonifier's 1-bit PWM `snd` output, in front of the audio pin. It gates the PWM stream with a first-order delta-sigma density set by an 8-bit gain level. The level ramps linearly up on `enable` rise and down on `enable` fall, so muting never produces a hard step.

## Interface

Parameters:
- `LEVEL_BITS`, 8: gain level width; full scale `LMAX = 2^LEVEL_BITS - 1`.
- `STEP_CLKS`, 25_200: clocks per one-LSB level step. Full fade = `LMAX*STEP_CLKS` clocks, about 255 ms at 25.2 MHz. Must be ≥ 2.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: 1 = play (fade in), 0 = mute (fade out). Level-sensitive.
- `snd_in`, input, 1: PWM audio from the sonifier.
- `snd`, output, 1: faded PWM audio, registered.
- `level`, output, `LEVEL_BITS`: current gain level.
- `busy`, output, 1: high in FADE_IN or FADE_OUT.
- `muted`, output, 1: high in MUTED.

## Operation

- State machine has four states: MUTED, FADE_IN, PLAYING, FADE_OUT.
  - MUTED: `level` = 0. On `enable`=1, go to FADE_IN.
  - FADE_IN: on `tick`, `level` += 1. When the new level equals LMAX, go to PLAYING on the same edge. On `enable`=0, go to FADE_OUT immediately. `level` holds that cycle and resumes from its current value.
  - PLAYING: `level` = LMAX. On `enable`=0, go to FADE_OUT.
  - FADE_OUT: on `tick`, `level` -= 1. When the new level equals 0, go to MUTED on the same edge. On `enable`=1, go to FADE_IN immediately from the current level.
- If an `enable` change and a `tick` occur in the same cycle, the direction change wins and `level` is not stepped that cycle.
- Tick generator: free-running counter from 0 to STEP_CLKS−1. `tick` is high when count = STEP_CLKS−1. It is cleared only by `reset`, not by state changes.
- Density gate:
  - `acc` (LEVEL_BITS wide) updates each clock as `{carry, acc} <= acc + level`, mod 2^LEVEL_BITS.
  - `gate` = carry.
  - Over any window of 2^LEVEL_BITS clocks at constant `level` = L, `gate` is high exactly L times.
- Output:
  - `snd <= snd_in & gate` when `level` < LMAX.
  - `snd <= snd_in` when `level` = LMAX, giving exact pass-through.
  - `snd` is 0 whenever `level` = 0.
- `level` never wraps. Increment saturates at LMAX and decrement at 0 by construction of the state transitions.

## Timing

- Reset values: state MUTED, `level` 0, `acc` 0, tick counter 0, `snd` 0, `busy` 0, `muted` 1.
- `snd` latency: 1 clock from `snd_in` and from `level`/`acc`, which are registered values of the prior cycle.
- `level`, `busy` and `muted` are registered and change on the edge where the state or level updates.
- `enable` edge to state change: 1 clock.
- Reset mid-fade: on the edge following `reset` high, all registers take their reset values. `snd` is 0 from that edge on.
- `enable` toggled every cycle: state alternates FADE_IN/FADE_OUT with `level` frozen. No glitch beyond the density set by the frozen level.

## Structure

- Shared package `logs_pkg` holds:
  - the state enum `fade_state_t` (MUTED, FADE_IN, PLAYING, FADE_OUT);
  - `LEVEL_BITS` and `STEP_CLKS` defaults, shared with the sonifier's top-level parameters.
- Sub-module: reuse the codebase's `logs_divider` (parameter N = STEP_CLKS) for `tick`. Do not write a new counter.
- Everything else (FSM, level register, delta-sigma accumulator, output flop) lives in `logs_fader`.

## Test plan

All scenarios use `LEVEL_BITS`=4 and `STEP_CLKS`=16 (LMAX = 15).

- Reset, hold `enable`=0, `snd_in`=1 for 1000 clocks → `snd`=0 throughout, `muted`=1, `level`=0.
- `enable`=1 from MUTED, `snd_in`=1 → `level` steps 1..15, one step per 16 clocks. PLAYING is reached within 15×16+16 clocks. Then `snd` equals `snd_in` delayed 1 clock, and `busy`=0.
- During FADE_IN, `snd_in`=1 → in every 16-clock plateau at level L, `snd` has exactly L ones.
- In FADE_IN at `level`=7, drop `enable` → next cycle FADE_OUT with `level`=7. `level` then decreases to 0, reaching MUTED.
- Assert `reset` in FADE_OUT at `level`=9 → next edge: `level`=0, `snd`=0, `muted`=1, `acc`=0.
- In PLAYING, drive `snd_in` as a 50% square wave with period 10 → `snd` matches it exactly, 1 clock late. With `snd_in`=0, `snd`=0 in every state.
